cnn_layer_sequencer: RTL

Parametrised successor to the fixed six-state CNN controller. It sequences NUM_LAYERS layer engines (conv, pool, FC) through a start/done handshake, drives the shared MAC layer-select mux, and pulses MAC and address-counter resets between layers. Software issues a command per layer (single-step) or one command for the whole network (run-all), then reads a done bitmap and an error code. It sits between the software register interface and the per-layer datapath engines.

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/seq_watchdog.sv | 29 ++
 rtl/cnn_layer_sequencer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN layer sequencer.
package cnn_pkg;

    localparam int CNN_NUM_LAYERS = 6;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START,
        WAIT,
        FINISH
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ORDER   = 2'd1,
        ERR_INDEX   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } seq_err_t;

endpackage

// File: rtl/seq_watchdog.sv
// WAIT-state watchdog: counts while run is high, flags expiry at all-ones.
// Only instantiated when CNN_SEQ_TIMEOUT_EN is defined.
module seq_watchdog
    import cnn_pkg::*;
#(
    parameter int TO_W = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic expired
);

    logic [TO_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!run) begin
            count <= '0;
        end else begin
            count <= count + TO_W'(1);
        end
    end

    assign expired = run && (&count);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Sequences NUM_LAYERS layer engines via start/done handshake, single-step or run-all.
// Optional WAIT watchdog enabled by defining CNN_SEQ_TIMEOUT_EN.
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int NUM_LAYERS = CNN_NUM_LAYERS,
    parameter int LW         = $clog2(NUM_LAYERS),
    parameter int TO_W       = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sw_go,
    input  logic                  sw_mode,
    input  logic [LW-1:0]         sw_layer,
    input  logic                  sw_abort,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic [NUM_LAYERS-1:0] layer_start,
    output logic [LW-1:0]         mac_layer,
    output logic                  mac_rst,
    output logic                  cnt_rst,
    output logic                  busy,
    output logic [LW-1:0]         cur_layer,
    output logic [NUM_LAYERS-1:0] done_mask,
    output logic [1:0]            err,
    output logic                  irq
);

    localparam logic [LW:0]   NUM_L = (LW + 1)'(NUM_LAYERS);
    localparam logic [LW-1:0] LAST  = LW'(NUM_LAYERS - 1);

    seq_state_t            state, state_d;
    seq_err_t              err_q, err_d;
    logic                  mode, mode_d;
    logic [LW-1:0]         cur_layer_d;
    logic [NUM_LAYERS-1:0] done_mask_d;
    logic [NUM_LAYERS-1:0] layer_start_d;
    logic                  clr_q, clr_d;
    logic                  irq_d;
    logic [LW-1:0]         target;
    logic                  bad_index;
    logic                  prev_done;
    logic                  timeout;

    assign target    = sw_mode ? '0 : sw_layer;
    assign bad_index = {1'b0, target} >= NUM_L;
    assign prev_done = done_mask[target - LW'(1)];

`ifdef CNN_SEQ_TIMEOUT_EN
    seq_watchdog #(.TO_W(TO_W)) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .run     (state == WAIT),
        .expired (timeout)
    );
`else
    // Never fires; TO_W only sizes the optional watchdog.
    assign timeout = (TO_W < 0);
`endif

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d       = state;
        err_d         = err_q;
        mode_d        = mode;
        cur_layer_d   = cur_layer;
        done_mask_d   = done_mask;
        layer_start_d = '0;
        clr_d         = 1'b0;
        irq_d         = 1'b0;

        unique case (state)
            IDLE: begin
                if (sw_go) begin
                    mode_d = sw_mode;
                    err_d  = ERR_NONE;
                    if (target == '0) begin
                        done_mask_d = '0;
                    end
                    if (bad_index) begin
                        err_d = ERR_INDEX;
                        irq_d = 1'b1;
                    end else if (target != '0 && !prev_done) begin
                        err_d = ERR_ORDER;
                        irq_d = 1'b1;
                    end else begin
                        state_d     = CLEAR;
                        cur_layer_d = target;
                        clr_d       = 1'b1;
                    end
                end
            end
            CLEAR: begin
                state_d       = START;
                layer_start_d = NUM_LAYERS'(1) << cur_layer;
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (layer_done[cur_layer]) begin
                    done_mask_d[cur_layer] = 1'b1;
                    if (mode && cur_layer != LAST) begin
                        state_d     = CLEAR;
                        cur_layer_d = cur_layer + LW'(1);
                        clr_d       = 1'b1;
                    end else begin
                        state_d = FINISH;
                        irq_d   = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    err_d   = ERR_TIMEOUT;
                    irq_d   = 1'b1;
                    clr_d   = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything above, including a same-cycle layer_done.
        if (sw_abort && state != IDLE) begin
            state_d       = IDLE;
            err_d         = err_q;
            cur_layer_d   = cur_layer;
            done_mask_d   = done_mask;
            layer_start_d = '0;
            irq_d         = 1'b0;
            clr_d         = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            err_q       <= ERR_NONE;
            mode        <= 1'b0;
            cur_layer   <= '0;
            done_mask   <= '0;
            layer_start <= '0;
            clr_q       <= 1'b0;
            irq         <= 1'b0;
        end else begin
            state       <= state_d;
            err_q       <= err_d;
            mode        <= mode_d;
            cur_layer   <= cur_layer_d;
            done_mask   <= done_mask_d;
            layer_start <= layer_start_d;
            clr_q       <= clr_d;
            irq         <= irq_d;
        end
    end

    assign mac_layer = cur_layer;
    assign mac_rst   = clr_q;
    assign cnt_rst   = clr_q;
    assign busy      = (state != IDLE);
    assign err       = err_q;

endmodule
